// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// mux_scan_sequencer
//   Steps the 4:1 mux selects round-robin over a,b,c,d, samples F on each
//   channel and hands the assembled 4-bit frame out over valid/ready.
//   Optional: define MUX_SCAN_PARITY_EN to add the frame_par output.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mux_scan_sequencer #(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       F,
  output logic       s1,
  output logic       s2,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic       frame_par,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(DWELL - 1);
  localparam logic [7:0] C_CNT_SMP  = 8'(SETTLE);

  state_t     state_q;
  logic [1:0] ch_q;
  logic [7:0] cnt_q;
  logic [3:0] shadow_q;
  logic [3:0] shadow_d;

  // Merge the current-edge sample so the frame load on the last dwell cycle
  // sees it even when SETTLE == DWELL-1.
  always_comb begin
    shadow_d = shadow_q;
    if ((state_q == ST_SCAN) && (cnt_q == C_CNT_SMP)) begin
      shadow_d[ch_q] = F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= 2'd0;
      cnt_q       <= 8'd0;
      shadow_q    <= 4'd0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      frame       <= 4'd0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      frame_par   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SCAN;
            ch_q    <= 2'd0;
            cnt_q   <= 8'd0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            busy    <= 1'b1;
          end
        end

        ST_SCAN: begin
          shadow_q <= shadow_d;
          if (cnt_q == C_CNT_LAST) begin
            cnt_q <= 8'd0;
            if (ch_q == 2'd3) begin
              // Selects stay at 11 through HOLD; only ch rewinds.
              frame       <= shadow_d;
              frame_valid <= 1'b1;
              ch_q        <= 2'd0;
              state_q     <= ST_HOLD;
`ifdef MUX_SCAN_PARITY_EN
              frame_par   <= ^shadow_d;
`endif
            end else begin
              ch_q     <= ch_q + 2'd1;
              {s1, s2} <= ch_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        ST_HOLD: begin
          if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
            ch_q        <= 2'd0;
            cnt_q       <= 8'd0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            if (continuous) begin
              state_q <= ST_SCAN;
            end else begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
